port_io: RTL



---
 rtl/port_io.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/port_io.sv
// Port-bus I/O responder: TX/RX FIFOs bridging to valid/ready streams, a free-running
// timer and a GPIO register, all decoded in a 4-word window at BASE_ADDR.

module port_io_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         do_reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           rd_ptr, wr_ptr;
    logic [CW-1:0]           count;
    logic                    do_push, do_pop;

    // Full/empty come from the pre-edge count, so a push on a full FIFO is
    // dropped even when the other side drains on the same edge.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module port_io #(
    parameter int                  WORD_SIZE  = 16,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR = 16'h0010,
    parameter int                  FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 do_reset_n,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    output logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [WORD_SIZE-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [WORD_SIZE-1:0] gpio_out
);
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_TIMER  = 2'd2;
    localparam logic [1:0] OFF_GPIO   = 2'd3;

    logic                 hit;
    logic [1:0]           off;
    logic                 tx_full, tx_empty, rx_full, rx_empty;
    logic [WORD_SIZE-1:0] rx_head;
    logic                 tx_drop;
    logic [WORD_SIZE-1:0] timer;
    logic [WORD_SIZE-1:0] status;
    logic                 wr_data, rd_data, wr_status, wr_timer, wr_gpio;

    assign hit       = (portaddr[WORD_SIZE-1:2] == BASE_ADDR[WORD_SIZE-1:2]);
    assign off       = portaddr[1:0];
    assign wr_data   = portset & hit & (off == OFF_DATA);
    assign rd_data   = portget & hit & (off == OFF_DATA);
    assign wr_status = portset & hit & (off == OFF_STATUS);
    assign wr_timer  = portset & hit & (off == OFF_TIMER);
    assign wr_gpio   = portset & hit & (off == OFF_GPIO);

    port_io_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .do_reset_n (do_reset_n),
        .push       (wr_data),
        .wdata      (portval),
        .pop        (tx_valid & tx_ready),
        .head       (tx_data),
        .full       (tx_full),
        .empty      (tx_empty)
    );

    port_io_fifo #(.W(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .do_reset_n (do_reset_n),
        .push       (rx_valid & rx_ready),
        .wdata      (rx_data),
        .pop        (rd_data),
        .head       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty)
    );

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    always_comb begin
        status    = '0;
        status[0] = ~rx_empty;
        status[1] = tx_full;
        status[2] = tx_drop;
        status[3] = tx_empty;
    end

    always_comb begin
        portout = '0;
        if (hit) begin
            case (off)
                OFF_DATA:   portout = rx_head;
                OFF_STATUS: portout = status;
                OFF_TIMER:  portout = timer;
                OFF_GPIO:   portout = gpio_out;
                default:    portout = '0;
            endcase
        end
    end

    // A CPU timer load wins over the free-running increment on the same edge.
    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) begin
            tx_drop  <= 1'b0;
            timer    <= '0;
            gpio_out <= '0;
        end else begin
            if (wr_data && tx_full)
                tx_drop <= 1'b1;
            else if (wr_status && portval[2])
                tx_drop <= 1'b0;
            timer <= wr_timer ? portval : timer + WORD_SIZE'(1);
            if (wr_gpio)
                gpio_out <= portval;
        end
    end
endmodule
